// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined two-level carry-lookahead adder/subtractor with valid/ready on both sides.
// Optional signed-overflow output is built when CLA_OVF_DETECT_EN is defined.
`timescale 1ns/1ps

module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVF_DETECT_EN
    ,
    output logic             ovf
`endif
);

    localparam int NG = WIDTH / GROUP;

    // Handshake: a beat moves whenever valid && ready on that side. The output register
    // advances when empty or being consumed, S1 advances when empty or S2 advances, and
    // the input is ready exactly when S1 can advance, so capacity is two beats.
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] g_q;
    logic             c0_q;
`ifdef CLA_OVF_DETECT_EN
    logic             a_msb_q;
    logic             b_msb_q;
`endif

    assign b_eff = sub ? ~b : b;

    always_ff @(posedge clk) begin
        if (in_valid && s1_adv) begin
            p_q  <= a ^ b_eff;
            g_q  <= a & b_eff;
            c0_q <= sub | cin;
`ifdef CLA_OVF_DETECT_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b_eff[WIDTH-1];
`endif
        end
    end

    logic [NG-1:0]  gp;
    logic [NG-1:0]  gg;
    logic [NG:0]    cg;
    logic [WIDTH:0] c;

    // Group propagate/generate, flattened sum-of-products within each group.
    always_comb begin : group_pg
        logic prop;
        prop = 1'b1;
        gp   = '0;
        gg   = '0;
        for (int k = 0; k < NG; k++) begin
            gp[k] = &p_q[k*GROUP +: GROUP];
            for (int m = 0; m < GROUP; m++) begin
                prop = g_q[k*GROUP+m];
                for (int n = m + 1; n < GROUP; n++) prop = prop & p_q[k*GROUP+n];
                gg[k] = gg[k] | prop;
            end
        end
    end

    // Second level: every group carry is expanded directly from c0 and the group P/G terms.
    always_comb begin : group_carry
        logic prop;
        prop  = 1'b1;
        cg    = '0;
        cg[0] = c0_q;
        for (int k = 1; k <= NG; k++) begin
            prop = c0_q;
            for (int n = 0; n < k; n++) prop = prop & gp[n];
            cg[k] = prop;
            for (int m = 0; m < k; m++) begin
                prop = gg[m];
                for (int n = m + 1; n < k; n++) prop = prop & gp[n];
                cg[k] = cg[k] | prop;
            end
        end
    end

    // In-group carries: full lookahead from the group's incoming carry.
    always_comb begin : inner_carry
        logic prop;
        prop = 1'b1;
        c    = '0;
        for (int k = 0; k < NG; k++) begin
            c[k*GROUP] = cg[k];
            for (int j = 1; j < GROUP; j++) begin
                prop = cg[k];
                for (int n = 0; n < j; n++) prop = prop & p_q[k*GROUP+n];
                c[k*GROUP+j] = prop;
                for (int m = 0; m < j; m++) begin
                    prop = g_q[k*GROUP+m];
                    for (int n = m + 1; n < j; n++) prop = prop & p_q[k*GROUP+n];
                    c[k*GROUP+j] = c[k*GROUP+j] | prop;
                end
            end
        end
        c[WIDTH] = cg[NG];
    end

    logic [WIDTH-1:0] sum_next;
    assign sum_next = p_q ^ c[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef CLA_OVF_DETECT_EN
            ovf       <= 1'b0;
`endif
        end else begin
            if (s1_adv) s1_valid <= in_valid;
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    sum  <= sum_next;
                    cout <= c[WIDTH];
`ifdef CLA_OVF_DETECT_EN
                    ovf  <= (a_msb_q == b_msb_q) && (sum_next[WIDTH-1] != a_msb_q);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed scenarios plus random traffic on a 32-bit and an 8-bit
// instance, scored against an arithmetic model. Define CLA_OVF_DETECT_EN to include ovf checks.
`timescale 1ns/1ps

module tb_cla_pipe_adder;

    localparam int W   = 32;
    localparam int W8  = 8;
    localparam int RW  = W + 2;
    localparam int RW8 = W8 + 2;
`ifdef CLA_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0]  a, b, sum;
    logic          in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [W8-1:0] a8, b8, sum8;

    cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef CLA_OVF_DETECT_EN
        , .ovf(ovf)
`endif
    );

    cla_pipe_adder #(.WIDTH(W8), .GROUP(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8)
`ifdef CLA_OVF_DETECT_EN
        , .ovf(ovf8)
`endif
    );

`ifndef CLA_OVF_DETECT_EN
    assign ovf  = 1'b0;
    assign ovf8 = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [RW-1:0]  exp_q[$];
    logic [RW8-1:0] exp_q8[$];

    // ---------------- reference model: {ovf, cout, sum} ----------------
    function automatic logic [33:0] model(input int w, input logic [31:0] a_v, input logic [31:0] b_v,
                                          input logic cin_v, input logic sub_v);
        longint unsigned m, ua, ub, t;
        longint          half, sa, sb, sr;
        logic            c, o;
        m    = (64'd1 << w) - 64'd1;
        half = longint'(64'd1 << (w - 1));
        ua   = {32'd0, a_v} & m;
        ub   = {32'd0, b_v} & m;
        sa   = (ua >= half) ? longint'(ua) - 2 * half : longint'(ua);
        sb   = (ub >= half) ? longint'(ub) - 2 * half : longint'(ub);
        if (sub_v) begin
            t  = (ua - ub) & m;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            t  = ua + ub + {63'd0, cin_v};
            c  = ((t >> w) & 64'd1) != 64'd0;
            t  = t & m;
            sr = sa + sb + longint'({63'd0, cin_v});
        end
        o = OVF_EN && ((sr >= half) || (sr < -half));
        return {o, c, t[31:0]};
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'd1 << (w - 1);
            3:       v = (32'd1 << (w - 1)) - 32'd1;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // ---------------- drivers ----------------
    // Observes the handshakes for the cycle about to close, updates the scoreboard, then
    // advances one clock. The caller compares got/exp when fired is set.
    task automatic tick32(output bit acc, output bit fired, output logic [RW-1:0] got,
                          output logic [RW-1:0] exp_v);
        logic [33:0] r;
        #1;
        acc   = in_valid && in_ready;
        fired = out_valid && out_ready;
        got   = {ovf, cout, sum};
        exp_v = 'x;
        if (fired && exp_q.size() > 0) exp_v = exp_q.pop_front();
        if (acc) begin
            r = model(W, a, b, cin, sub);
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick8(output bit fired, output logic [RW8-1:0] got, output logic [RW8-1:0] exp_v);
        logic [33:0] r;
        #1;
        fired = out_valid8 && out_ready8;
        got   = {ovf8, cout8, sum8};
        exp_v = 'x;
        if (fired && exp_q8.size() > 0) exp_v = exp_q8.pop_front();
        if (in_valid8 && in_ready8) begin
            r = model(W8, {24'd0, a8}, {24'd0, b8}, cin8, sub8);
            exp_q8.push_back({r[33], r[32], r[7:0]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic sv);
        in_valid = 1'b1; a = av; b = bv; cin = cv; sub = sv;
    endtask

    task automatic idle();
        in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; idle(); out_ready = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", sum); end
        n_checks++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_cout_ovf: got %b want 00", {cout, ovf}); end
        n_checks++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8: got %b want 0", out_valid8); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_carry_wrap();
        bit acc, fired; logic [RW-1:0] got, exp_v;
        out_ready = 1'b1;
        beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        tick32(acc, fired, got, exp_v);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL wrap_accept: got %b want 1", acc); end
        idle();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_latency1: out_valid %b want 0", out_valid); end
        tick32(acc, fired, got, exp_v);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_latency2: out_valid %b want 1", out_valid); end
        n_checks++; if ({cout, sum} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL wrap_value: got %h want 100000000", {cout, sum}); end
        tick32(acc, fired, got, exp_v);
        n_checks++; if (fired !== 1'b1 || got !== exp_v) begin n_fail++; $display("FAIL wrap_score: got %h want %h", got, exp_v); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_bubble: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_sub();
        bit acc, fired; logic [RW-1:0] got, exp_v;
        out_ready = 1'b1;
        for (int i = 0; i < 12 && (i < 2 || exp_q.size() > 0); i++) begin
            if (i == 0) beat(32'd5, 32'd7, 1'b1, 1'b1);
            else if (i == 1) beat(32'd7, 32'd5, 1'b0, 1'b1);
            else idle();
            tick32(acc, fired, got, exp_v);
            if (fired) begin
                n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL sub_result: got %h want %h", got, exp_v); end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sub_drain: %0d results still pending, want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit acc, fired; logic [RW-1:0] got, exp_v;
        int first, last, cnt;
        first = -1; last = -1; cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: beat(32'd1, 32'd2, 1'b0, 1'b0);
                1: beat(32'd10, 32'd20, 1'b0, 1'b0);
                2: beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
                default: idle();
            endcase
            tick32(acc, fired, got, exp_v);
            if (fired) begin
                cnt++; if (first < 0) first = i; last = i;
                n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL b2b_result: got %h want %h", got, exp_v); end
            end
        end
        n_checks++; if (cnt != 3 || first != 2 || last != 4) begin
            n_fail++; $display("FAIL b2b_timing: count %0d first %0d last %0d, want 3 2 4", cnt, first, last);
        end
    endtask

    task automatic test_stall();
        bit acc, fired; logic [RW-1:0] got, exp_v;
        out_ready = 1'b0;
        beat(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        tick32(acc, fired, got, exp_v);
        beat(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        tick32(acc, fired, got, exp_v);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL stall_accept2: got %b want 1", acc); end
        beat(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_valid !== 1'b1 || {cout, sum} !== exp_q[0][W:0]) begin
                n_fail++; $display("FAIL stall_hold: valid %b value %h want 1 %h", out_valid, {cout, sum}, exp_q[0][W:0]);
            end
            tick32(acc, fired, got, exp_v);
            n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: accepted %b want 0", acc); end
        end
        out_ready = 1'b1;
        tick32(acc, fired, got, exp_v);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL stall_third_accept: got %b want 1", acc); end
        n_checks++; if (fired !== 1'b1 || got !== exp_v) begin n_fail++; $display("FAIL stall_drain1: got %h want %h", got, exp_v); end
        idle();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            tick32(acc, fired, got, exp_v);
            if (fired) begin
                n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL stall_drain: got %h want %h", got, exp_v); end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_pending: %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit acc, fired; logic [RW-1:0] got, exp_v;
        out_ready = 1'b0;
        beat(32'd100, 32'd200, 1'b0, 1'b0);
        tick32(acc, fired, got, exp_v);
        beat(32'd300, 32'd400, 1'b0, 1'b0);
        tick32(acc, fired, got, exp_v);
        idle();
        rst_n = 1'b0;
        tick32(acc, fired, got, exp_v);
        rst_n = 1'b1;
        exp_q.delete();
        n_checks++; if (out_valid !== 1'b0 || sum !== '0) begin n_fail++; $display("FAIL midreset_out: valid %b sum %h want 0 0", out_valid, sum); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick32(acc, fired, got, exp_v);
            n_checks++; if (fired !== 1'b0) begin n_fail++; $display("FAIL midreset_stale: result %h appeared, want none", got); end
        end
    endtask

`ifdef CLA_OVF_DETECT_EN
    task automatic test_ovf();
        bit acc, fired; logic [RW-1:0] got, exp_v;
        logic want[3];
        int   k;
        want = '{1'b1, 1'b1, 1'b0};
        k = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: beat(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
                1: beat(32'h8000_0000, 32'd1, 1'b0, 1'b1);
                2: beat(32'd5, 32'd3, 1'b0, 1'b0);
                default: idle();
            endcase
            tick32(acc, fired, got, exp_v);
            if (fired && k < 3) begin
                n_checks++; if (got[W+1] !== want[k]) begin n_fail++; $display("FAIL ovf_%0d: got %b want %b", k, got[W+1], want[k]); end
                n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL ovf_result: got %h want %h", got, exp_v); end
                k++;
            end
        end
        n_checks++; if (k != 3) begin n_fail++; $display("FAIL ovf_count: got %0d results want 3", k); end
    endtask
`endif

    task automatic test_random32();
        bit acc, fired; logic [RW-1:0] got, exp_v;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) beat(pick(W), pick(W), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else idle();
            out_ready = ($urandom_range(0, 9) < 7);
            tick32(acc, fired, got, exp_v);
            if (fired) begin
                n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL rand32: got %h want %h", got, exp_v); end
            end
        end
        idle(); out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            tick32(acc, fired, got, exp_v);
            if (fired) begin
                n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL rand32_drain: got %h want %h", got, exp_v); end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand32_pending: %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_width8();
        bit fired; logic [RW8-1:0] got, exp_v;
        logic [7:0] da[6], db[6];
        logic       dc[6], ds[6];
        logic [31:0] ra, rb;
        da = '{8'hFF, 8'h05, 8'h07, 8'h01, 8'h0A, 8'hFF};
        db = '{8'h01, 8'h07, 8'h05, 8'h02, 8'h14, 8'hFF};
        dc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        ds = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 406; i++) begin
            if (i < 6) begin
                in_valid8 = 1'b1; a8 = da[i]; b8 = db[i]; cin8 = dc[i]; sub8 = ds[i]; out_ready8 = 1'b1;
            end else begin
                ra = pick(W8); rb = pick(W8);
                in_valid8 = ($urandom_range(0, 9) < 7); a8 = ra[7:0]; b8 = rb[7:0];
                cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
                out_ready8 = ($urandom_range(0, 9) < 6);
            end
            tick8(fired, got, exp_v);
            if (fired) begin
                n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL rand8: got %h want %h", got, exp_v); end
            end
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        for (int i = 0; i < 10 && exp_q8.size() > 0; i++) begin
            tick8(fired, got, exp_v);
            if (fired) begin
                n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL rand8_drain: got %h want %h", got, exp_v); end
            end
        end
        n_checks++; if (exp_q8.size() != 0 || out_valid8 !== 1'b0) begin
            n_fail++; $display("FAIL rand8_pending: %0d left valid %b, want 0 0", exp_q8.size(), out_valid8);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_carry_wrap();
        test_sub();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef CLA_OVF_DETECT_EN
        test_ovf();
`endif
        test_random32();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
